conv_pool_engine: RTL and testbench
===================================

Name: conv_pool_engine

Overview:
- Multi-channel post-convolution stage: takes the raster-ordered conv result stream of CH parallel feature-map lanes, applies optional ReLU, then 2x2 stride-2 pooling (max or average, run-time selectable).
- Emits pooled words with a linear output address, a per-lane argmax code and an end-of-frame pulse.
- Successor of the single-lane max-pool stage: generalises data width, map size and lane count, and adds avg mode, ReLU and frame restart.
- Sits between the systolic array outputs and the feature-map writeback.

Parameters:
- DW, 16, signed sample width per lane.
- CH, 4, number of parallel lanes (output channels).
- MAP, 14, input map side length (must be even, >=2); output side is MAP/2.
- AW, 16, output address width.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse: abort any frame, clear counters, latch mode and relu_en.
- mode  input  1  0 = max pool, 1 = average pool; sampled only on start.
- relu_en  input  1  1 = clamp negative samples to 0 before pooling; sampled only on start.
- in_valid  input  1  in_data carries one raster sample per lane this cycle.
- in_data  input  CH*DW  lane k in bits [k*DW +: DW], signed.
- out_valid  output  1  pooled word valid, 1-cycle pulse.
- out_data  output  CH*DW  pooled result, same lane packing.
- out_addr  output  AW  (row/2)*(MAP/2)+(col/2).
- out_argmax  output  2*CH  per lane, window position of max: 0=TL, 1=TR, 2=BL, 3=BR; 0 in avg mode.
- frame_done  output  1  pulses together with the last out_valid of a frame.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values: every output is 0, counters are 0, latched mode=0, latched relu=0, line buffer contents are don't-care.
- No backpressure. in_valid may be gapped arbitrarily. Only valid cycles advance col (0..MAP-1) and row (0..MAP-1).
- Pre-processing: when latched relu=1, a negative sample becomes 0. This is applied per lane before any comparison or sum.
- Even row, even col: hold the sample in the horizontal register.
- Even row, odd col: combine the held sample with the current one, then write line buffer entry col/2. Stored per lane:
  - max mode: the larger value plus its 1-bit position.
  - avg mode: the DW+1-bit sum.
- Odd row, even col: hold the sample.
- Odd row, odd col: combine the held sample, the current sample and line buffer entry col/2.
  - out_valid=1 on the next clock edge (latency 1 cycle after the 4th sample).
- Max mode:
  - Signed compare. Ties resolve to the lowest position index (TL < TR < BL < BR).
  - out_argmax gives the winning index.
- Avg mode:
  - 4-sample sum in DW+2 bits, arithmetic shift right by 2 (floor toward -inf). The result always fits DW, so no saturation.
  - out_argmax = 0.
- Outputs hold their value when out_valid=0. out_addr increments 0..(MAP/2)^2-1 across a frame.
- Frame end: on the sample at row=MAP-1, col=MAP-1, frame_done pulses with the final out_valid. Counters wrap to 0 and the next frame reuses the latched mode and relu.
- start:
  - Takes priority over in_valid in the same cycle; that sample is dropped.
  - Counters clear and the partial window is discarded. No out_valid or frame_done is produced for the aborted frame.
  - An output already registered from the previous cycle still presents.
- reset_n=0 mid-frame: same clearing as start, and outputs are also forced to 0.
- Line buffer: MAP/2 entries x CH lanes x (DW+1) bits. It is written only on even rows, read only on odd rows, so there is no read/write collision.

Decomposition:
- Shared package conv_pkg:
  - position encoding constants POS_TL..POS_BR.
  - mode constants MODE_MAX, MODE_AVG.
  - function for lane slicing.
- Sub-module pool_lane: one lane's ReLU, pair-combine and window-combine datapath, instantiated CH times via generate.
- Counters, line buffer addressing and output control stay in conv_pool_engine.

Test Plan:
- Max, ReLU off, CH=1, MAP=4, input values 0..15 raster -> 4 outputs 5,7,13,15 at addr 0..3, argmax=3 each, frame_done with the 4th output.
- Avg mode, window {-3,-2,-1,-1} -> sum -7, output -2 (floor); window {1,1,1,2} -> 1.
- ReLU on, max mode, window {-5,-9,-1,-7} -> output 0, argmax 0 (tie on zero resolves to TL).
- CH=4 lanes with distinct constants 10,-20,30,-40, max mode -> each lane reproduces its constant, argmax 0, no cross-lane leakage.
- Gapped in_valid (1 of 3 cycles), start pulse mid row 2, then full frame -> no output from aborted frame, clean addr 0..(MAP/2)^2-1 afterwards.
- reset_n low for 1 cycle mid-frame -> all outputs 0 next cycle, next frame matches golden model; back-to-back frames without start -> addr wraps to 0.

Source files
------------

// File: rtl/conv_pool_engine_pkg.sv
// conv_pkg: window position codes, pooling mode codes and lane slicing shared by conv_pool_engine.
package conv_pkg;
  localparam logic [1:0] POS_TL = 2'd0;
  localparam logic [1:0] POS_TR = 2'd1;
  localparam logic [1:0] POS_BL = 2'd2;
  localparam logic [1:0] POS_BR = 2'd3;
  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_AVG = 1'b1;
  function automatic int lane_lo(input int k, input int dw);
    return k * dw;
  endfunction
endpackage

// File: rtl/conv_pool_engine_if.sv
// conv_pool_engine_if: control, raster input stream and pooled output of conv_pool_engine.
interface conv_pool_engine_if #(parameter int DW = 16, parameter int CH = 4, parameter int AW = 16);
  logic start;
  logic mode;
  logic relu_en;
  logic in_valid;
  logic [CH*DW-1:0] in_data;
  logic out_valid;
  logic [CH*DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic [2*CH-1:0] out_argmax;
  logic frame_done;
  modport master (output start, mode, relu_en, in_valid, in_data,
                  input out_valid, out_data, out_addr, out_argmax, frame_done);
  modport slave (input start, mode, relu_en, in_valid, in_data,
                 output out_valid, out_data, out_addr, out_argmax, frame_done);
endinterface

// File: rtl/conv_pool_engine_lane.sv
// pool_lane: one lane's ReLU, horizontal pair combine and 2x2 window combine (purely combinational).
module pool_lane import conv_pkg::*; #(parameter int DW = 16) (
  input  logic                 i_mode,
  input  logic                 i_relu,
  input  logic signed [DW-1:0] i_sample,
  input  logic signed [DW-1:0] i_held,
  input  logic [DW+1:0]        i_lb,
  output logic signed [DW-1:0] o_proc,
  output logic [DW+1:0]        o_pair,
  output logic signed [DW-1:0] o_win,
  output logic [1:0]           o_arg
);
  logic signed [DW-1:0] w_pmax;
  logic signed [DW-1:0] w_top;
  logic signed [DW:0]   w_psum;
  logic signed [DW+1:0] w_wsum;
  logic                 w_ppos;
  logic                 w_bot;
  // strict greater-than everywhere so ties keep the lower window position
  always_comb begin
    o_proc = (i_relu && i_sample[DW-1]) ? '0 : i_sample;
    w_ppos = o_proc > i_held;
    w_pmax = w_ppos ? o_proc : i_held;
    w_psum = {i_held[DW-1], i_held} + {o_proc[DW-1], o_proc};
    o_pair = (i_mode == MODE_AVG) ? {1'b0, w_psum} : {w_ppos, w_pmax[DW-1], w_pmax};
    w_top  = i_lb[DW-1:0];
    w_bot  = w_pmax > w_top;
    w_wsum = {i_lb[DW], i_lb[DW:0]} + {w_psum[DW], w_psum};
    o_win  = (i_mode == MODE_AVG) ? w_wsum[DW+1:2] : (w_bot ? w_pmax : w_top);
    o_arg  = (i_mode == MODE_AVG) ? POS_TL :
             w_bot ? (w_ppos ? POS_BR : POS_BL) : (i_lb[DW+1] ? POS_TR : POS_TL);
  end
endmodule

// File: rtl/conv_pool_engine.sv
// conv_pool_engine: CH-lane ReLU + 2x2 stride-2 max/avg pooling over a raster MAPxMAP stream.
module conv_pool_engine import conv_pkg::*; #(
  parameter int DW  = 16,
  parameter int CH  = 4,
  parameter int MAP = 14,
  parameter int AW  = 16
) (
  input logic clk,
  input logic reset_n,
  conv_pool_engine_if.slave bus
);
  localparam int HALF = MAP / 2;
  localparam int LW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CW = LW + 1;
  localparam logic [CW-1:0] LAST = CW'(MAP - 1);
  logic                     r_mode;
  logic                     r_relu;
  logic [CW-1:0]            r_row;
  logic [CW-1:0]            r_col;
  logic [AW-1:0]            r_addr;
  logic [CH-1:0][DW-1:0]    r_held;
  logic [CH-1:0][DW+1:0]    r_lb [HALF];
  logic [CH-1:0][DW-1:0]    w_proc;
  logic [CH-1:0][DW-1:0]    w_win;
  logic [CH-1:0][DW+1:0]    w_pair;
  logic [CH-1:0][1:0]       w_arg;
  logic [LW-1:0]            w_idx;
  logic                     w_fire;
  logic                     w_last;
  assign w_idx  = r_col[CW-1:1];
  assign w_fire = bus.in_valid & ~bus.start;
  assign w_last = (r_row == LAST) && (r_col == LAST);
  for (genvar k = 0; k < CH; k++) begin : g_lane
    pool_lane #(.DW(DW)) u_lane (
      .i_mode  (r_mode),
      .i_relu  (r_relu),
      .i_sample(bus.in_data[lane_lo(k, DW) +: DW]),
      .i_held  (r_held[k]),
      .i_lb    (r_lb[w_idx][k]),
      .o_proc  (w_proc[k]),
      .o_pair  (w_pair[k]),
      .o_win   (w_win[k]),
      .o_arg   (w_arg[k])
    );
  end
  // datapath storage carries no reset: every read is preceded by a write in the same frame
  always_ff @(posedge clk) begin
    if (w_fire && !r_col[0]) r_held <= w_proc;
    if (reset_n && w_fire && !r_row[0] && r_col[0]) r_lb[w_idx] <= w_pair;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mode         <= MODE_MAX;
      r_relu         <= 1'b0;
      r_row          <= '0;
      r_col          <= '0;
      r_addr         <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_addr   <= '0;
      bus.out_argmax <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      if (bus.start) begin
        r_mode <= bus.mode;
        r_relu <= bus.relu_en;
        r_row  <= '0;
        r_col  <= '0;
        r_addr <= '0;
      end else if (bus.in_valid) begin
        r_col <= (r_col == LAST) ? '0 : r_col + CW'(1);
        if (r_col == LAST) r_row <= (r_row == LAST) ? '0 : r_row + CW'(1);
        if (r_row[0] && r_col[0]) begin
          bus.out_valid  <= 1'b1;
          bus.out_data   <= w_win;
          bus.out_argmax <= w_arg;
          bus.out_addr   <= r_addr;
          bus.frame_done <= w_last;
          r_addr         <= w_last ? '0 : r_addr + AW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_pool_engine.sv
// tb_conv_pool_engine: randomized + directed stimulus, window-level reference model, queue scoreboard.
module tb_conv_pool_engine;
  localparam int DW = 16, CH = 4, MAP = 4, AW = 16, HALF = MAP / 2;
  typedef struct {
    logic [CH*DW-1:0] d;
    logic [2*CH-1:0]  a;
    logic [AW-1:0]    ad;
    logic             fd;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  exp_t q[$];
  exp_t me;
  int   errs = 0;
  int   checks = 0;
  int   img[MAP][MAP][CH];
  int   m_row = 0, m_col = 0;
  logic m_mode = 1'b0, m_relu = 1'b0;
  always #5 clk = ~clk;
  conv_pool_engine_if #(.DW(DW), .CH(CH), .AW(AW)) bus();
  conv_pool_engine #(.DW(DW), .CH(CH), .MAP(MAP), .AW(AW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [CH*DW-1:0] pat(input int kind, input int r, input int c);
    int t0[4] = '{-3, -2, -1, -1};
    int t1[4] = '{1, 1, 1, 2};
    int t2[4] = '{-5, -9, -1, -7};
    int t3[4] = '{4, -4, 4, 9};
    int kc[4] = '{10, -20, 30, -40};
    int p, v, x;
    logic [CH*DW-1:0] o;
    p = (r % 2) * 2 + (c % 2);
    v = r * MAP + c;
    o = '0;
    for (int k = 0; k < CH; k++) begin
      if (kind == 0) x = (k == 0) ? v : (k == 1) ? -v : (k == 2) ? 3 : v - 8;
      else if (kind == 1) x = (k == 0) ? t0[p] : (k == 1) ? t1[p] : (k == 2) ? t2[p] : t3[p];
      else if (kind == 2) x = kc[k];
      else x = int'($urandom_range(0, 65535)) - 32768;
      o[k*DW +: DW] = DW'(x);
    end
    return o;
  endfunction
  // expected pooled word computed from the stored raster image of the window just completed
  task automatic push(input int r, input int c);
    exp_t e;
    int v[4];
    int best, s, qv;
    e.d = '0;
    e.a = '0;
    for (int k = 0; k < CH; k++) begin
      s = 0;
      for (int p = 0; p < 4; p++) begin
        v[p] = img[r - 1 + p / 2][c - 1 + p % 2][k];
        if (m_relu && v[p] < 0) v[p] = 0;
        s += v[p];
      end
      best = 0;
      if (m_mode) begin
        qv = s / 4;
        if (s < 0 && s % 4 != 0) qv--;
      end else begin
        for (int p = 1; p < 4; p++) if (v[p] > v[best]) best = p;
        qv = v[best];
      end
      e.d[k*DW +: DW] = DW'(qv);
      e.a[2*k +: 2] = 2'(best);
    end
    e.ad = AW'((r / 2) * HALF + c / 2);
    e.fd = (r == MAP - 1) && (c == MAP - 1);
    q.push_back(e);
  endtask
  task automatic cyc(input logic st, input logic md, input logic rl, input logic v,
                     input logic [CH*DW-1:0] d);
    @(negedge clk);
    bus.start = st;
    bus.mode = md;
    bus.relu_en = rl;
    bus.in_valid = v;
    bus.in_data = d;
    if (st) begin
      m_mode = md;
      m_relu = rl;
      m_row = 0;
      m_col = 0;
    end else if (v) begin
      for (int k = 0; k < CH; k++) img[m_row][m_col][k] = int'($signed(d[k*DW +: DW]));
      if (m_row % 2 == 1 && m_col % 2 == 1) push(m_row, m_col);
      m_col++;
      if (m_col == MAP) begin
        m_col = 0;
        m_row = (m_row + 1) % MAP;
      end
    end
  endtask
  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask
  task automatic frame(input int kind, input int gap, input int n);
    for (int i = 0; i < n; i++) begin
      if (gap == 1) repeat (2) idle();
      else if (gap == 2) repeat ($urandom_range(0, 3)) idle();
      cyc(1'b0, 1'b0, 1'b0, 1'b1, pat(kind, m_row, m_col));
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_data"}, 64'(bus.out_data), 64'(0));
    chk({tag, "_addr"}, 64'(bus.out_addr), 64'(0));
    chk({tag, "_argmax"}, 64'(bus.out_argmax), 64'(0));
    chk({tag, "_done"}, 64'(bus.frame_done), 64'(0));
  endtask
  task automatic mid_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_zero("midreset");
    m_mode = 1'b0;
    m_relu = 1'b0;
    m_row = 0;
    m_col = 0;
  endtask
  always @(negedge clk) begin
    if (bus.frame_done && !bus.out_valid) begin
      checks++;
      errs++;
      $display("FAIL done_without_valid: got frame_done=1 with out_valid=0, required 0");
    end
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_out: got out_valid=1 addr=%0d, required no output", bus.out_addr);
      end else begin
        me = q.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(me.d));
        chk("out_argmax", 64'(bus.out_argmax), 64'(me.a));
        chk("out_addr", 64'(bus.out_addr), 64'(me.ad));
        chk("frame_done", 64'(bus.frame_done), 64'(me.fd));
      end
    end
  end
  initial begin
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.relu_en = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    frame(0, 0, 16);
    repeat (2) idle();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
    frame(1, 0, 16);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
    frame(1, 0, 16);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    frame(2, 0, 16);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    frame(3, 1, 10);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, pat(3, 0, 0));
    frame(3, 1, 16);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
    frame(3, 2, 6);
    mid_reset();
    frame(3, 0, 16);
    frame(3, 0, 16);
    repeat (30) begin
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          pat(3, 0, 0));
      frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16 * int'($urandom_range(1, 2)));
    end
    repeat (4) idle();
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
